// File: rtl/tiny8_types.sv
// Shared tiny8 datapath types: word, ALU opcode, register index and the
// occupancy encoding used by the execute stage's two-entry output buffer.
package tiny8_types;

  localparam int WORD_W = 8;
  localparam int REGIDX_W = 3;

  typedef logic [WORD_W-1:0]   tiny8_word;
  typedef logic [REGIDX_W-1:0] tiny8_regidx;

  // Codes 4..7 are unassigned and produce a zero result.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_DEC = 3'd2,
    ALU_MUL = 3'd3
  } tiny8_aluop;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/alu.sv
// Purely combinational tiny8 ALU; all results wrap modulo 2^8.
module alu
  import tiny8_types::*;
(
  input  tiny8_aluop i_op,
  input  tiny8_word  i_a,
  input  tiny8_word  i_b,
  output tiny8_word  o_f
);

  always_comb begin
    o_f = '0;
    case (i_op)
      ALU_ADD: o_f = i_a + i_b;
      ALU_SUB: o_f = i_a - i_b;
      ALU_DEC: o_f = i_a - 8'd1;
      // Only the low nibble of B takes part in the multiply.
      ALU_MUL: o_f = i_a * {4'h0, i_b[3:0]};
      default: o_f = '0;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// tiny8 execute stage: ALU on the input side feeding a main/skid result buffer.
// Define TINY8_ZERO_FLAG_EN to add the out_zero port and its per-entry storage.
module exec_stage
  import tiny8_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  tiny8_aluop  in_aluop,
  input  tiny8_word   in_a,
  input  tiny8_word   in_b,
  input  tiny8_regidx in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output tiny8_word   out_f,
  output tiny8_regidx out_rd
`ifdef TINY8_ZERO_FLAG_EN
  ,
  output logic        out_zero
`endif
);

  skid_state_e r_state;
  skid_state_e w_next_state;
  logic        r_in_ready;
  tiny8_word   r_main_f;
  tiny8_regidx r_main_rd;
  tiny8_word   r_skid_f;
  tiny8_regidx r_skid_rd;
  tiny8_word   w_alu_f;
  logic        w_accept;
  logic        w_deliver;
  logic        w_load_main_alu;
  logic        w_load_main_skid;
  logic        w_load_skid;
`ifdef TINY8_ZERO_FLAG_EN
  logic        r_main_zero;
  logic        r_skid_zero;
  logic        w_alu_zero;
`endif

  alu u_alu (
    .i_op (in_aluop),
    .i_a  (in_a),
    .i_b  (in_b),
    .o_f  (w_alu_f)
  );

  assign w_accept  = in_valid && r_in_ready;
  assign w_deliver = out_valid && out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_f     = r_main_f;
  assign out_rd    = r_main_rd;
`ifdef TINY8_ZERO_FLAG_EN
  assign w_alu_zero = (w_alu_f == '0);
  assign out_zero   = r_main_zero;
`endif

  always_comb begin
    w_next_state     = r_state;
    w_load_main_alu  = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_next_state    = ST_ONE;
            w_load_main_alu = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_deliver) begin
            w_load_main_alu = 1'b1;
          end else if (w_accept) begin
            w_next_state = ST_TWO;
            w_load_skid  = 1'b1;
          end else if (w_deliver) begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_deliver) begin
            w_next_state     = ST_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_next_state = ST_EMPTY;
      endcase
    end
  end

  // in_ready is its own flop so upstream never sees a combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != ST_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_f    <= '0;
      r_main_rd   <= '0;
`ifdef TINY8_ZERO_FLAG_EN
      r_main_zero <= 1'b1;
`endif
    end else if (w_load_main_alu) begin
      r_main_f    <= w_alu_f;
      r_main_rd   <= in_rd;
`ifdef TINY8_ZERO_FLAG_EN
      r_main_zero <= w_alu_zero;
`endif
    end else if (w_load_main_skid) begin
      r_main_f    <= r_skid_f;
      r_main_rd   <= r_skid_rd;
`ifdef TINY8_ZERO_FLAG_EN
      r_main_zero <= r_skid_zero;
`endif
    end
  end

  // Skid contents are only observed in TWO, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_load_skid) begin
      r_skid_f    <= w_alu_f;
      r_skid_rd   <= in_rd;
`ifdef TINY8_ZERO_FLAG_EN
      r_skid_zero <= w_alu_zero;
`endif
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed cases plus randomized traffic
// compared against a queue-based model of the two-entry result buffer.
module tb_exec_stage;
  import tiny8_types::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  tiny8_aluop  in_aluop = ALU_ADD;
  tiny8_word   in_a = '0;
  tiny8_word   in_b = '0;
  tiny8_regidx in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  tiny8_word   out_f;
  tiny8_regidx out_rd;
`ifdef TINY8_ZERO_FLAG_EN
  logic        out_zero;
`endif

  exec_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_aluop  (in_aluop),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_f     (out_f),
    .out_rd    (out_rd)
`ifdef TINY8_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int f;
    int rd;
  } result_t;

  result_t modelQ[$];
  bit      modelReady = 1'b1;
  int      testsRun = 0;
  int      failCount = 0;

  function automatic int refAlu(input int op, input int a, input int b);
    case (op)
      0:       return (a + b) % 256;
      1:       return (a - b + 256) % 256;
      2:       return (a + 255) % 256;
      3:       return (a * (b % 16)) % 256;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelReady = 1'b1;
  endtask

  // Advance the model using the inputs that were sampled at this edge.
  task automatic modelStep();
    bit      acc;
    bit      del;
    result_t r;
    acc = in_valid && modelReady;
    del = (modelQ.size() > 0) && out_ready;
    r.f  = refAlu(int'(in_aluop), int'(in_a), int'(in_b));
    r.rd = int'(in_rd);
    if (flush) begin
      modelQ.delete();
    end else begin
      if (del) void'(modelQ.pop_front());
      if (acc) modelQ.push_back(r);
    end
    modelReady = (modelQ.size() < 2);
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(modelQ.size() > 0));
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(modelReady));
    if (modelQ.size() > 0) begin
      checkOutput({tag, ".out_f"}, 32'(out_f), 32'(modelQ[0].f));
      checkOutput({tag, ".out_rd"}, 32'(out_rd), 32'(modelQ[0].rd));
`ifdef TINY8_ZERO_FLAG_EN
      checkOutput({tag, ".out_zero"}, 32'(out_zero), 32'(modelQ[0].f == 0));
`endif
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, ".out_f"}, 32'(out_f), 32'd0);
    checkOutput({tag, ".out_rd"}, 32'(out_rd), 32'd0);
`ifdef TINY8_ZERO_FLAG_EN
    checkOutput({tag, ".out_zero"}, 32'(out_zero), 32'd1);
`endif
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic applyStimulus(input string tag, input logic v, input logic [2:0] op,
                               input int a, input int b, input int rd,
                               input logic ordy, input logic fl);
    in_valid  = v;
    in_aluop  = tiny8_aluop'(op);
    in_a      = tiny8_word'(a);
    in_b      = tiny8_word'(b);
    in_rd     = tiny8_regidx'(rd);
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    modelStep();
    #1;
    checkState(tag);
  endtask

  task automatic idle(input string tag, input logic ordy);
    applyStimulus(tag, 1'b0, 3'd0, 0, 0, 0, ordy, 1'b0);
  endtask

  initial begin
    logic [2:0] rop;
    #12;
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add, latency one
    applyStimulus("add5+3", 1'b1, 3'd0, 5, 3, 2, 1'b1, 1'b0);
    idle("drain", 1'b1);

    // Wrap cases and unknown opcode
    applyStimulus("sub0-1", 1'b1, 3'd1, 0, 1, 1, 1'b1, 1'b0);
    applyStimulus("dec1", 1'b1, 3'd2, 1, 0, 3, 1'b1, 1'b0);
    applyStimulus("mul20x1f", 1'b1, 3'd3, 8'h20, 8'h1F, 4, 1'b1, 1'b0);
    applyStimulus("unkop", 1'b1, 3'd6, 8'h33, 8'h44, 7, 1'b1, 1'b0);
    idle("drain2", 1'b1);

    // Back-pressure: third op waits until a slot frees
    applyStimulus("bp1", 1'b1, 3'd0, 1, 1, 1, 1'b0, 1'b0);
    applyStimulus("bp2", 1'b1, 3'd0, 2, 2, 2, 1'b0, 1'b0);
    applyStimulus("bp3hold", 1'b1, 3'd0, 3, 3, 3, 1'b0, 1'b0);
    applyStimulus("bp3hold2", 1'b1, 3'd0, 3, 3, 3, 1'b0, 1'b0);
    applyStimulus("bprel1", 1'b1, 3'd0, 3, 3, 3, 1'b1, 1'b0);
    applyStimulus("bprel2", 1'b1, 3'd0, 3, 3, 3, 1'b1, 1'b0);
    idle("bprel3", 1'b1);
    idle("bpdone", 1'b1);

    // Streaming
    for (int i = 0; i < 8; i++)
      applyStimulus("stream", 1'b1, 3'(i % 4), 10 + i, i, i, 1'b1, 1'b0);
    idle("streamdone", 1'b1);

    // Flush while full with a simultaneous request
    applyStimulus("fl1", 1'b1, 3'd0, 9, 9, 5, 1'b0, 1'b0);
    applyStimulus("fl2", 1'b1, 3'd0, 7, 7, 6, 1'b0, 1'b0);
    applyStimulus("flush", 1'b1, 3'd0, 4, 4, 7, 1'b1, 1'b1);
    idle("postflush", 1'b1);

    // Asynchronous reset while full, asserted between edges
    applyStimulus("ar1", 1'b1, 3'd1, 50, 8, 1, 1'b0, 1'b0);
    applyStimulus("ar2", 1'b1, 3'd3, 3, 5, 2, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 checkResetValues("asyncrst");
    modelReset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    applyStimulus("postrst", 1'b1, 3'd0, 8'h80, 8'h80, 3, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rop = 3'($urandom_range(0, 7));
      applyStimulus("rand", 1'($urandom_range(0, 1)), rop, int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port flush, input, 1, synchronous discard of all held results.
REQ-004 SHALL have port in_valid, input, 1, upstream (decode) presents an operation.
REQ-005 SHALL have port in_ready, output, 1, stage can accept; driven from a register only.
REQ-006 SHALL have port in_aluop, input, tiny8_aluop, operation select.
REQ-007 SHALL have port in_a, input, tiny8_word (8), operand A.
REQ-008 SHALL have port in_b, input, tiny8_word (8), operand B.
REQ-009 SHALL have port in_rd, input, 3, destination register index.
REQ-010 SHALL have port out_valid, output, 1, result held for writeback.
REQ-011 SHALL have port out_ready, input, 1, writeback consumes the result.
REQ-012 SHALL have port out_f, output, 8, registered ALU result.
REQ-013 SHALL have port out_rd, output, 3, registered destination index.
REQ-014 SHALL have port out_zero, output, 1, out_f == 0 (present only per REQ-030).

Function
REQ-015 SHALL accept when in_valid && in_ready, and SHALL deliver when out_valid && out_ready.
REQ-016 SHALL compute result combinationally from in_* at acceptance: add a+b, sub a-b, dec a-1, mul a*b[3:0]; all mod 2^8.
REQ-017 SHALL present an accepted result on out_* the cycle after acceptance (latency 1) when the main slot is free or draining.
REQ-018 SHALL hold two entries (main, skid); state EMPTY/ONE/TWO; out_* always reflect main.
REQ-019 Transitions:
 - EMPTY: accept -> ONE.
 - ONE: accept && deliver -> ONE (new result into main); accept only -> TWO (new into skid); deliver only -> EMPTY.
 - TWO: deliver -> ONE (skid moves to main); no accept possible.
REQ-020 SHALL set in_ready = (state != TWO), registered.
REQ-021 SHALL keep out_f/out_rd/out_zero stable while out_valid && !out_ready.
REQ-022 SHALL preserve acceptance order; no result dropped or duplicated except by flush.
REQ-023 flush SHALL take priority over accept and deliver: next state EMPTY, input ignored that cycle, in_ready = 1 next cycle.
REQ-024 Unknown aluop SHALL yield result 0 and still complete the handshake.

Reset
REQ-025 On rst_n low, asynchronously: state EMPTY, out_valid 0, in_ready 1, out_f 0, out_rd 0, out_zero 1.
REQ-026 Reset mid-transfer SHALL discard all entries; first acceptance after release follows REQ-017.
REQ-027 Data registers SHALL need no reset beyond REQ-025 values.

Configuration
REQ-028 Macro TINY8_ZERO_FLAG_EN SHALL control the zero flag.
REQ-029 Defined: out_zero is stored per entry alongside out_f and follows it through skid.
REQ-030 Undefined: out_zero port and its storage are absent; all other behaviour is identical.

Structure
REQ-031 tiny8_word, tiny8_aluop and a tiny8_regidx (3-bit) typedef SHALL live in tiny8_types.
REQ-032 SHALL instantiate the existing alu sub-module once on the input side; no duplicate arithmetic.
REQ-033 Skid logic SHALL be inline; no further sub-modules.

Verification
REQ-034 Reset then add a=0x05 b=0x03 rd=2, out_ready=1 -> next cycle out_valid=1, out_f=0x08, out_rd=2, out_zero=0.
REQ-035 Wrap: sub 0x00-0x01 -> 0xFF; dec 0x01 -> 0x00, out_zero=1; mul 0x20*0x1F -> 0xE0 (b[3:0]=0xF).
REQ-036 Back-pressure: out_ready=0, three back-to-back ops add 1+1, 2+2, 3+3 -> in_ready low after 2nd; release out_ready -> 0x02, 0x04, then 0x06 in order.
REQ-037 Streaming: in_valid=1, out_ready=1 for 8 cycles -> 8 results, one per cycle, in_ready never drops.
REQ-038 Flush in TWO with simultaneous in_valid -> next cycle out_valid=0, in_ready=1, flushed input never appears.
REQ-039 rst_n asserted in TWO between clock edges -> outputs reach REQ-025 values immediately, without waiting for a clock.
